// File: rtl/mips_hzd_pkg.sv
// mips_hzd_pkg: shared entry layout, width defaults and stage indices for the hazard scoreboard
package mips_hzd_pkg;
  localparam int AW_D = 5;
  localparam int TW_D = 2;
  localparam int STG_E = 0;
  localparam int STG_M = 1;
  localparam int STG_W = 2;
  typedef struct packed {
    logic            valid;
    logic [AW_D-1:0] a3;
    logic [TW_D-1:0] tnew;
  } hzd_entry_t;
endpackage

// File: rtl/hzd_port_match.sv
// hzd_port_match: youngest-match select for one read port, giving forward data, hit and stall
import mips_hzd_pkg::*;
module hzd_port_match #(
  parameter int STAGES = 3,
  parameter int AW = AW_D,
  parameter int DW = 32,
  parameter int TW = TW_D
) (
  input  logic [STAGES-1:0]    i_valid,
  input  logic [STAGES*AW-1:0] i_a3,
  input  logic [STAGES*TW-1:0] i_tnew,
  input  logic [STAGES*DW-1:0] i_stage_wd,
  input  logic                 i_use,
  input  logic [AW-1:0]        i_addr,
  input  logic [TW-1:0]        i_tuse,
  input  logic [DW-1:0]        i_rf_rd,
  output logic [DW-1:0]        o_data,
  output logic                 o_hit,
  output logic                 o_stall
);
  // scan oldest to youngest so the youngest matching entry has the final say
  always_comb begin
    o_data = i_rf_rd;
    o_hit = 1'b0;
    o_stall = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--)
      if (i_use && |i_addr && i_valid[k] && i_a3[k*AW +: AW] == i_addr) begin
        o_hit = i_tnew[k*TW +: TW] == '0;
        o_data = o_hit ? i_stage_wd[k*DW +: DW] : i_rf_rd;
        o_stall = i_tnew[k*TW +: TW] > i_tuse;
      end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: Tnew/Tuse scoreboard with forwarding select; HAZARD_STATS_EN adds a saturating stall counter
import mips_hzd_pkg::*;
module hazard_scoreboard #(
  parameter int STAGES = 3,
  parameter int RPORTS = 2,
  parameter int AW = AW_D,
  parameter int DW = 32,
  parameter int TW = TW_D
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_a3,
  input  logic [TW-1:0]        issue_tnew,
  input  logic                 flush,
  input  logic [RPORTS-1:0]    rd_use,
  input  logic [RPORTS*AW-1:0] rd_addr,
  input  logic [RPORTS*TW-1:0] rd_tuse,
  input  logic [RPORTS*DW-1:0] rf_rd,
  input  logic [STAGES*DW-1:0] stage_wd,
  output logic [RPORTS*DW-1:0] fwd_data,
  output logic [RPORTS-1:0]    fwd_hit,
  output logic                 stall
`ifdef HAZARD_STATS_EN
  , output logic [31:0]        stall_cnt
`endif
);
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] a3;
    logic [TW-1:0] tnew;
  } entry_t;
  entry_t [STAGES-1:0] r_ent;
  logic [STAGES-1:0] w_valid;
  logic [STAGES*AW-1:0] w_a3;
  logic [STAGES*TW-1:0] w_tnew;
  logic [RPORTS-1:0] w_port_stall;
  // entry 0 takes the D instruction (or a bubble on stall); older entries age one stage with tnew counting down
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_ent <= '0;
    else if (flush) r_ent <= '0;
    else begin
      r_ent[STG_E].valid <= !stall && issue_valid && |issue_a3;
      r_ent[STG_E].a3 <= stall ? '0 : issue_a3;
      r_ent[STG_E].tnew <= stall ? '0 : issue_tnew;
      for (int k = STG_M; k < STAGES; k++) begin
        r_ent[k].valid <= r_ent[k-1].valid;
        r_ent[k].a3 <= r_ent[k-1].a3;
        r_ent[k].tnew <= |r_ent[k-1].tnew ? r_ent[k-1].tnew - TW'(1) : '0;
      end
    end
  // flatten entries into per-field vectors for the port matchers
  always_comb begin
    w_valid = '0;
    w_a3 = '0;
    w_tnew = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_valid[k] = r_ent[k].valid;
      w_a3[k*AW +: AW] = r_ent[k].a3;
      w_tnew[k*TW +: TW] = r_ent[k].tnew;
    end
  end
  for (genvar p = 0; p < RPORTS; p++) begin : g_port
    hzd_port_match #(.STAGES(STAGES), .AW(AW), .DW(DW), .TW(TW)) u_match (
      .i_valid(w_valid),
      .i_a3(w_a3),
      .i_tnew(w_tnew),
      .i_stage_wd(stage_wd),
      .i_use(rd_use[p]),
      .i_addr(rd_addr[p*AW +: AW]),
      .i_tuse(rd_tuse[p*TW +: TW]),
      .i_rf_rd(rf_rd[p*DW +: DW]),
      .o_data(fwd_data[p*DW +: DW]),
      .o_hit(fwd_hit[p]),
      .o_stall(w_port_stall[p])
    );
  end
  assign stall = |w_port_stall;
`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cnt;
  // count stalled edges, holding at all-ones; only reset clears it
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_stall_cnt <= '0;
    else if (stall && ~&r_stall_cnt) r_stall_cnt <= r_stall_cnt + 32'd1;
  assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of stalls, forwarding, flush, reset and optional stall counter
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic reset;
  logic issue_valid;
  logic [4:0] issue_a3;
  logic [1:0] issue_tnew;
  logic flush;
  logic [1:0] rd_use;
  logic [9:0] rd_addr;
  logic [3:0] rd_tuse;
  logic [63:0] rf_rd;
  logic [95:0] stage_wd;
  logic [63:0] fwd_data;
  logic [1:0] fwd_hit;
  logic stall;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
`endif
  int total = 0;
  int bad = 0;

  hazard_scoreboard dut (
    .clk(clk),
    .reset(reset),
    .issue_valid(issue_valid),
    .issue_a3(issue_a3),
    .issue_tnew(issue_tnew),
    .flush(flush),
    .rd_use(rd_use),
    .rd_addr(rd_addr),
    .rd_tuse(rd_tuse),
    .rf_rd(rf_rd),
    .stage_wd(stage_wd),
    .fwd_data(fwd_data),
    .fwd_hit(fwd_hit),
    .stall(stall)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic issue(input logic v, input logic [4:0] a, input logic [1:0] t);
    issue_valid = v;
    issue_a3 = a;
    issue_tnew = t;
  endtask

  task automatic rd(input int p, input logic u, input logic [4:0] a, input logic [1:0] t);
    rd_use[p] = u;
    rd_addr[p*5 +: 5] = a;
    rd_tuse[p*2 +: 2] = t;
  endtask

  task automatic idle();
    issue(1'b0, 5'd0, 2'd0);
    rd_use = '0;
    rd_addr = '0;
    rd_tuse = '0;
    flush = 1'b0;
  endtask

  task automatic clean();
    @(negedge clk);
    idle();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    rf_rd = {32'h2222_2222, 32'h1111_1111};
    stage_wd = {32'h0C0C_0002, 32'h0C0C_0001, 32'h0C0C_0000};
    #3 reset = 1'b0;
    issue(1'b1, 5'd8, 2'd3);
    rd(0, 1'b1, 5'd8, 2'd0);
    repeat (2) @(negedge clk);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
    total++; if (fwd_hit !== 2'b00) begin bad++; $display("FAIL rst_hit got=%b exp=00", fwd_hit); end
    total++; if (fwd_data !== rf_rd) begin bad++; $display("FAIL rst_data got=%h exp=%h", fwd_data, rf_rd); end
    @(negedge clk);
    idle();
    reset = 1'b1;
  endtask

  // lw $8 Tnew=2 against a Tuse=0 reader: stalls while in E and M, forwards from W
  task automatic test_lw_stall();
    clean();
    @(negedge clk);
    issue(1'b1, 5'd8, 2'd2);
    @(negedge clk);
    issue(1'b0, 5'd0, 2'd0);
    rd(0, 1'b1, 5'd8, 2'd0);
    stage_wd = {32'h5555_0002, 32'h5555_0001, 32'h5555_0000};
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lw_stall1 got=%b exp=1", stall); end
    @(negedge clk);
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lw_stall2 got=%b exp=1", stall); end
    total++; if (fwd_hit[0] !== 1'b0) begin bad++; $display("FAIL lw_hit_early got=%b exp=0", fwd_hit[0]); end
    @(negedge clk);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lw_release got=%b exp=0", stall); end
    total++; if (fwd_hit[0] !== 1'b1) begin bad++; $display("FAIL lw_hit got=%b exp=1", fwd_hit[0]); end
    total++; if (fwd_data[31:0] !== 32'h5555_0002) begin bad++; $display("FAIL lw_data got=%h exp=55550002", fwd_data[31:0]); end
    idle();
  endtask

  // addu $9 Tnew=1 against a Tuse=1 reader: no stall, result forwarded once it exists
  task automatic test_addu_forward();
    clean();
    @(negedge clk);
    issue(1'b1, 5'd9, 2'd1);
    @(negedge clk);
    issue(1'b0, 5'd0, 2'd0);
    rd(1, 1'b1, 5'd9, 2'd1);
    stage_wd = {32'hDEAD_0002, 32'h0000_1234, 32'hDEAD_0000};
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL addu_stall got=%b exp=0", stall); end
    total++; if (fwd_hit[1] !== 1'b0) begin bad++; $display("FAIL addu_hit_early got=%b exp=0", fwd_hit[1]); end
    total++; if (fwd_data[63:32] !== 32'h2222_2222) begin bad++; $display("FAIL addu_data_early got=%h exp=22222222", fwd_data[63:32]); end
    @(negedge clk);
    #1;
    total++; if (fwd_hit[1] !== 1'b1) begin bad++; $display("FAIL addu_hit got=%b exp=1", fwd_hit[1]); end
    total++; if (fwd_data[63:32] !== 32'h0000_1234) begin bad++; $display("FAIL addu_data got=%h exp=00001234", fwd_data[63:32]); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL addu_stall2 got=%b exp=0", stall); end
    idle();
  endtask

  // $5 written by E and W: the younger E value must win; a disabled port must not hit
  task automatic test_youngest();
    clean();
    @(negedge clk);
    issue(1'b1, 5'd5, 2'd0);
    @(negedge clk);
    issue(1'b0, 5'd0, 2'd0);
    @(negedge clk);
    issue(1'b1, 5'd5, 2'd0);
    @(negedge clk);
    issue(1'b0, 5'd0, 2'd0);
    rd(0, 1'b1, 5'd5, 2'd0);
    rd(1, 1'b1, 5'd6, 2'd0);
    stage_wd = {32'h0000_BBBB, 32'h0000_7777, 32'h0000_AAAA};
    #1;
    total++; if (fwd_data[31:0] !== 32'h0000_AAAA) begin bad++; $display("FAIL young_data got=%h exp=0000aaaa", fwd_data[31:0]); end
    total++; if (fwd_hit !== 2'b01) begin bad++; $display("FAIL young_hit got=%b exp=01", fwd_hit); end
    total++; if (fwd_data[63:32] !== 32'h2222_2222) begin bad++; $display("FAIL young_miss got=%h exp=22222222", fwd_data[63:32]); end
    rd(0, 1'b0, 5'd5, 2'd0);
    #1;
    total++; if (fwd_hit[0] !== 1'b0) begin bad++; $display("FAIL young_nouse got=%b exp=0", fwd_hit[0]); end
    idle();
  endtask

  task automatic test_zero();
    clean();
    @(negedge clk);
    issue(1'b1, 5'd0, 2'd0);
    @(negedge clk);
    issue(1'b0, 5'd0, 2'd0);
    rd(0, 1'b1, 5'd0, 2'd0);
    stage_wd = {32'h0000_0F02, 32'h0000_0F01, 32'h0000_0F00};
    #1;
    total++; if (fwd_hit[0] !== 1'b0) begin bad++; $display("FAIL zero_hit got=%b exp=0", fwd_hit[0]); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL zero_stall got=%b exp=0", stall); end
    total++; if (fwd_data[31:0] !== 32'h1111_1111) begin bad++; $display("FAIL zero_data got=%h exp=11111111", fwd_data[31:0]); end
    idle();
  endtask

  task automatic test_flush();
    clean();
    @(negedge clk);
    issue(1'b1, 5'd8, 2'd2);
    @(negedge clk);
    issue(1'b0, 5'd0, 2'd0);
    rd(0, 1'b1, 5'd8, 2'd0);
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL flush_pre got=%b exp=1", stall); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", stall); end
    rd_use = '0;
    issue(1'b1, 5'd7, 2'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    issue(1'b0, 5'd0, 2'd0);
    rd(1, 1'b1, 5'd7, 2'd0);
    #1;
    total++; if (fwd_hit[1] !== 1'b0) begin bad++; $display("FAIL flush_drop got=%b exp=0", fwd_hit[1]); end
    idle();
  endtask

  task automatic test_async_reset();
    clean();
    @(negedge clk);
    issue(1'b1, 5'd8, 2'd2);
    @(negedge clk);
    issue(1'b0, 5'd0, 2'd0);
    rd(0, 1'b1, 5'd8, 2'd0);
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b exp=1", stall); end
    #2 reset = 1'b0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL arst_drop got=%b exp=0", stall); end
    total++; if (fwd_data !== rf_rd) begin bad++; $display("FAIL arst_data got=%h exp=%h", fwd_data, rf_rd); end
    @(negedge clk);
    reset = 1'b1;
    rd_use = '0;
    issue(1'b1, 5'd8, 2'd2);
    @(negedge clk);
    issue(1'b0, 5'd0, 2'd0);
    rd(0, 1'b1, 5'd8, 2'd0);
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL arst_first_edge got=%b exp=1", stall); end
    idle();
  endtask

  // back-to-back writers: $3 ages to M with Tnew worn down to 0, $4 sits in E
  task automatic test_back_to_back();
    clean();
    @(negedge clk);
    issue(1'b1, 5'd3, 2'd1);
    @(negedge clk);
    issue(1'b1, 5'd4, 2'd0);
    @(negedge clk);
    issue(1'b0, 5'd0, 2'd0);
    rd(0, 1'b1, 5'd3, 2'd0);
    rd(1, 1'b1, 5'd4, 2'd0);
    stage_wd = {32'h0000_00C2, 32'h0000_00C1, 32'h0000_00C0};
    #1;
    total++; if (fwd_hit !== 2'b11) begin bad++; $display("FAIL b2b_hit got=%b exp=11", fwd_hit); end
    total++; if (fwd_data !== {32'h0000_00C0, 32'h0000_00C1}) begin bad++; $display("FAIL b2b_data got=%h exp=000000c0000000c1", fwd_data); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%b exp=0", stall); end
    idle();
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    idle();
    reset = 1'b0;
    #1;
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL stats_reset got=%0d exp=0", stall_cnt); end
    @(negedge clk);
    reset = 1'b1;
    issue(1'b1, 5'd8, 2'd3);
    @(negedge clk);
    issue(1'b0, 5'd0, 2'd0);
    rd(0, 1'b1, 5'd8, 2'd0);
    repeat (3) @(negedge clk);
    #1;
    total++; if (stall_cnt !== 32'd3) begin bad++; $display("FAIL stats_count got=%0d exp=3", stall_cnt); end
    rd_use = '0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    total++; if (stall_cnt !== 32'd3) begin bad++; $display("FAIL stats_flush got=%0d exp=3", stall_cnt); end
    idle();
  endtask
`endif

  initial begin
    test_reset();
    test_lw_stall();
    test_addu_forward();
    test_youngest();
    test_zero();
    test_flush();
    test_async_reset();
    test_back_to_back();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
